// File: rtl/clipped_relu_pipe.sv
// Two-stage clipped-ReLU / squared-clipped-ReLU activation for the NNUE datapath.
// Optional saturation statistics counter enabled by `define CLIPPED_RELU_SAT_CNT_EN.
module clipped_relu_pipe #(
    parameter int LANES     = 16,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int SHIFT     = 2,
    parameter int CLIP_MAX  = 127,
    parameter int SQR_SHIFT = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
    input  logic                   stats_clr,
    output logic [15:0]            sat_count
);

    localparam logic [IN_W-1:0]    CAP_IN  = IN_W'(CLIP_MAX);
    localparam logic [2*OUT_W-1:0] CAP_SQ  = (2*OUT_W)'(CLIP_MAX);
    localparam logic [OUT_W-1:0]   CAP_OUT = OUT_W'(CLIP_MAX);

    // Compare happens on the full-width shifted word so large inputs never alias below the ceiling.
    function automatic logic [OUT_W-1:0] clip_lane(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] t;
        t = x >> SHIFT;
        if (x[IN_W-1]) begin
            return {OUT_W{1'b0}};
        end else if (t > CAP_IN) begin
            return CAP_OUT;
        end else begin
            return OUT_W'(t);
        end
    endfunction

    function automatic logic over_ceiling(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] t;
        t = x >> SHIFT;
        return (!x[IN_W-1]) && (t > CAP_IN);
    endfunction

    function automatic logic [OUT_W-1:0] square_lane(input logic [OUT_W-1:0] c);
        logic [2*OUT_W-1:0] p;
        logic [2*OUT_W-1:0] s;
        p = (2*OUT_W)'(c) * (2*OUT_W)'(c);
        s = p >> SQR_SHIFT;
        if (s > CAP_SQ) begin
            return CAP_OUT;
        end else begin
            return OUT_W'(s);
        end
    endfunction

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic                   w_accept;
    logic [LANES*OUT_W-1:0] w_clip;
    logic [LANES*OUT_W-1:0] w_y;

    logic                   r_s1_valid;
    logic                   r_s1_mode;
    logic                   r_s1_last;
    logic [LANES*OUT_W-1:0] r_s1_c;
    logic                   r_s2_valid;
    logic                   r_s2_last;
    logic [LANES*OUT_W-1:0] r_s2_y;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign in_ready = w_s1_adv;

    // Per-lane clip of the incoming beat.
    always_comb begin
        w_clip = {(LANES*OUT_W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_clip[i*OUT_W +: OUT_W] = clip_lane(in_data[i*IN_W +: IN_W]);
        end
    end

    // Per-lane activation selected by the mode captured with the beat.
    always_comb begin
        w_y = {(LANES*OUT_W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (r_s1_mode) begin
                w_y[i*OUT_W +: OUT_W] = square_lane(r_s1_c[i*OUT_W +: OUT_W]);
            end else begin
                w_y[i*OUT_W +: OUT_W] = r_s1_c[i*OUT_W +: OUT_W];
            end
        end
    end

    // Stage 1: clipped lanes plus sideband.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_c     <= {(LANES*OUT_W){1'b0}};
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mode <= mode;
                r_s1_last <= in_last;
                r_s1_c    <= w_clip;
            end
        end
    end

    // Stage 2: final activations; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_y     <= {(LANES*OUT_W){1'b0}};
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_last <= r_s1_last;
                r_s2_y    <= w_y;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_y;
    assign out_last  = r_s2_last;

`ifdef CLIPPED_RELU_SAT_CNT_EN
    localparam int CNT_W = $clog2(LANES + 1);

    logic [CNT_W-1:0] w_hits;
    logic [16:0]      w_sum;
    logic [15:0]      r_sat_count;

    // Number of lanes in the incoming beat that clip at the ceiling.
    always_comb begin
        w_hits = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_hits = w_hits + CNT_W'(over_ceiling(in_data[i*IN_W +: IN_W]));
        end
    end

    assign w_sum = {1'b0, r_sat_count} + 17'(w_hits);

    // Saturating counter; a clear discards the same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= 16'h0000;
        end else if (stats_clr) begin
            r_sat_count <= 16'h0000;
        end else if (w_accept) begin
            r_sat_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = stats_clr ^ w_accept;
    assign sat_count      = 16'h0000;
`endif

endmodule
